joypad_port: RTL and testbench
==============================

# joypad_port

Memory-mapped bus responder for the `cpu_2a03` controller ports. It answers CPU reads at $4016/$4017 and CPU writes at $4016, as the slave end of the CPU address/data/rw bus. It emulates the strobe latch and the two 4021-style 8-bit parallel-in/serial-out shift registers of standard NES pads. The block sits beside RAM and APU on the CPU bus; button state arrives in parallel from the board or testbench.

## Interface

Parameters:
- none

Ports:
- `clock`  in  1  CPU clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  16  CPU address bus.
- `rw`  in  1  1 = read, 0 = write.
- `data_in`  in  8  CPU write data.
- `data_out`  out  8  read data; valid only while `data_oe` is high.
- `data_oe`  out  1  high for the cycle after a decoded read; top level muxes `data_out` onto the bidir bus.
- `pad1_buttons`  in  8  pad 1 state, 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right (bit0..bit7).
- `pad2_buttons`  in  8  pad 2 state, same ordering.
- `strobe`  out  1  current $4016 bit0 latch; drives external pad latch pins.

## Operation

- Address decode uses full 16-bit equality only. Hits are: read $4016 (pad 1), read $4017 (pad 2), and write $4016 (strobe). Write $4017 belongs to the APU and is ignored. All other addresses produce no effect and keep `data_oe`=0.
- Button inputs pass through a 2-flop synchronizer per bit (`sync1`, `sync2`). Only `sync2` values are used.
- Strobe latch: on a write to $4016, `strobe` <= `data_in[0]`. Bits 7:1 are ignored.
- Two shift registers, `sr1` and `sr2`, each 8 bits.
  - While `strobe`=1, both reload from `sync2` every cycle.
  - While `strobe`=0, each register holds except on a read of its own address.
  - On a read of its own address, the register shifts right one place with a 1 shifted into bit7.
- Read data: `data_out[0]` = bit0 of the addressed register as it was before the edge.
  - With `strobe`=1, this is the live synchronized A button, and no shift occurs; the reload dominates.
- After 8 reads with `strobe`=0, every further read returns bit0=1 until the next reload.
- A read of $4016 shifts only `sr1`; a read of $4017 shifts only `sr2`.
- Same-cycle cases:
  - A write of $4016 with data 1 reloads in the same edge it sets `strobe`.
  - A write of 0 stops reloading from the next edge, so the registers hold the value loaded on the write edge.

## Timing

- Reset values: `strobe`=0, `sr1`=`sr2`=8'h00, synchronizers 0, `data_out`=8'h00, `data_oe`=0.
- Bus access presented in cycle n is sampled at rising edge n.
- For reads, `data_out` and `data_oe` are registered at edge n and valid until edge n+1, where the CPU latches them. At edge n+1 `data_oe` returns to 0 unless cycle n+1 is also a decoded read.
- The shift caused by a read takes effect at edge n. Back-to-back reads in consecutive cycles return consecutive bits.
- Write to $4016: `strobe` is updated at edge n and visible on the port after edge n.
- Button-to-register latency: a change on `pad*_buttons` reaches `sync2` two edges later. With `strobe`=1 it is loaded into `sr*` on the third edge.
- Reset asserted mid-sequence clears the shift position asynchronously. Reads after reset release return bit0=0 (`sr`=0) until a reload, with 1s filling from the top.

## Configuration

- `JOYPAD_OPEN_BUS_EN` defined: `data_out[7:5]` = 3'b010 on every decoded read, modelling the $40 open-bus residue of the 2A03. A read with bit 1 therefore returns $41.
- Not defined: `data_out[7:1]` = 0, and reads return $00/$01 only.
- The macro changes no timing or state behaviour.

## Test plan

- Reset: hold `reset`=1 for 3 cycles. Then `strobe`=0, `data_oe`=0, `data_out`=$00. A read of $4016 then returns bit0=0.
- Latch and serialize: set `pad1_buttons`=8'b1000_0101 and wait 3 cycles. Write $01 then $00 to $4016, then read $4016 ten times. The bit0 sequence must be 1,0,1,0,0,0,0,1,1,1.
- Strobe held: with `strobe`=1 and `pad1_buttons`=8'h01, four reads of $4016 all return bit0=1. Clearing `pad1_buttons[0]` makes reads return 0 within 3 cycles.
- Independent ports: `pad1`=$FF, `pad2`=$00, strobe pulse. Alternating reads of $4016/$4017 give 1 and 0 respectively for 8 pairs, then 1 and 1.
- Decode: write $01 to $4017 leaves `strobe`=0. A read of $4018 keeps `data_oe`=0 and does not shift `sr1` or `sr2`.
- Reset mid-read: after 3 reads of $4016, assert `reset` for 1 cycle. The next read returns bit0=0, and `strobe` is 0.
- Build both with and without `JOYPAD_OPEN_BUS_EN`. Check `data_out` is $41/$40 versus $01/$00.

Source files
------------

// File: rtl/joypad_port.sv
// NES controller port responder: $4016 strobe latch plus two 4021-style serial pads.
// Define JOYPAD_OPEN_BUS_EN to return the $40 open-bus residue in data_out[7:5].
module joypad_port (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        rw,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  pad1_buttons,
   input  logic [7:0]  pad2_buttons,
   output logic        strobe
);

`ifdef JOYPAD_OPEN_BUS_EN
   localparam logic [6:0] READ_UPPER = 7'b010_0000;
`else
   localparam logic [6:0] READ_UPPER = '0;
`endif

   logic [7:0] sync1_pad1_q, sync2_pad1_q;
   logic [7:0] sync1_pad2_q, sync2_pad2_q;
   logic [7:0] sr1_q, sr1_d;
   logic [7:0] sr2_q, sr2_d;
   logic       strobe_q, strobe_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_oe_q, data_oe_d;

   logic rd_pad1, rd_pad2, wr_strobe, reload, read_bit;

   always_comb begin
      rd_pad1   = rw  && (addr == 16'h4016);
      rd_pad2   = rw  && (addr == 16'h4017);
      wr_strobe = !rw && (addr == 16'h4016);

      strobe_d = wr_strobe ? data_in[0] : strobe_q;
      // A write of 1 reloads on its own edge; a write of 0 still reloads once (old strobe).
      reload   = strobe_q || (wr_strobe && data_in[0]);

      sr1_d = sr1_q;
      sr2_d = sr2_q;
      if (reload) begin
         sr1_d = sync2_pad1_q;
         sr2_d = sync2_pad2_q;
      end else begin
         if (rd_pad1) sr1_d = {1'b1, sr1_q[7:1]};
         if (rd_pad2) sr2_d = {1'b1, sr2_q[7:1]};
      end

      // While strobed, reads see the live synchronized A button rather than the stale copy.
      read_bit = 1'b0;
      if (rd_pad1)      read_bit = strobe_q ? sync2_pad1_q[0] : sr1_q[0];
      else if (rd_pad2) read_bit = strobe_q ? sync2_pad2_q[0] : sr2_q[0];

      data_oe_d  = rd_pad1 || rd_pad2;
      data_out_d = data_oe_d ? {READ_UPPER, read_bit} : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_pad1_q <= '0;
         sync2_pad1_q <= '0;
         sync1_pad2_q <= '0;
         sync2_pad2_q <= '0;
         sr1_q        <= '0;
         sr2_q        <= '0;
         strobe_q     <= 1'b0;
         data_out_q   <= '0;
         data_oe_q    <= 1'b0;
      end else begin
         sync1_pad1_q <= pad1_buttons;
         sync2_pad1_q <= sync1_pad1_q;
         sync1_pad2_q <= pad2_buttons;
         sync2_pad2_q <= sync1_pad2_q;
         sr1_q        <= sr1_d;
         sr2_q        <= sr2_d;
         strobe_q     <= strobe_d;
         data_out_q   <= data_out_d;
         data_oe_q    <= data_oe_d;
      end
   end

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign strobe   = strobe_q;

endmodule

// File: tb/tb_joypad_port.sv
// Directed scoreboard bench for joypad_port; expected read bytes are queued as reads are issued.
module tb_joypad_port;

`ifdef JOYPAD_OPEN_BUS_EN
   localparam logic [6:0] UPPER = 7'b010_0000;
`else
   localparam logic [6:0] UPPER = '0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        rw = 1'b1;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  pad1_buttons = '0;
   logic [7:0]  pad2_buttons = '0;
   logic        strobe;

   logic [7:0]  exp_q[$];
   int          tests = 0;
   int          fails = 0;

   joypad_port dut (
      .clock(clock), .reset(reset), .addr(addr), .rw(rw), .data_in(data_in),
      .data_out(data_out), .data_oe(data_oe),
      .pad1_buttons(pad1_buttons), .pad2_buttons(pad2_buttons), .strobe(strobe)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         addr = 16'h0000; rw = 1'b1;
      end
   endtask

   // One bus cycle; a decoded read pushes its expected byte, popped once the DUT registers it.
   task automatic bus(input string tag, input logic [15:0] a, input logic r,
                      input logic [7:0] d, input logic exp_bit);
      logic decoded;
      logic [7:0] e;
      @(negedge clock);
      addr = a; rw = r; data_in = d;
      decoded = r && (a == 16'h4016 || a == 16'h4017);
      if (decoded) exp_q.push_back({UPPER, exp_bit});
      @(posedge clock); #1;
      check({tag, ".oe"}, {7'b0, data_oe}, {7'b0, decoded});
      if (decoded) begin
         e = exp_q.pop_front();
         check({tag, ".data"}, data_out, e);
      end
      addr = 16'h0000; rw = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic exp_bit);
      bus(tag, a, 1'b1, 8'h00, exp_bit);
   endtask

   task automatic wr(input string tag, input logic [7:0] d);
      bus(tag, 16'h4016, 1'b0, d, 1'b0);
   endtask

   initial begin
      logic [9:0] seq;

      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock); reset = 1'b0;
      #1;
      check("rst.strobe", {7'b0, strobe}, 8'h00);
      check("rst.oe", {7'b0, data_oe}, 8'h00);
      check("rst.data", data_out, 8'h00);
      rd("rst.read", 16'h4016, 1'b0);

      // Latch and serialize
      pad1_buttons = 8'b1000_0101;
      idle(3);
      wr("lat.w1", 8'h01);
      check("lat.strobe1", {7'b0, strobe}, 8'h01);
      wr("lat.w0", 8'h00);
      check("lat.strobe0", {7'b0, strobe}, 8'h00);
      seq = 10'b1110000101; // bit i = expected bit0 of read i
      for (int i = 0; i < 10; i++) rd($sformatf("lat.r%0d", i), 16'h4016, seq[i]);

      // Strobe held: reads show live A button, no shifting
      pad1_buttons = 8'h01;
      idle(3);
      wr("hold.w1", 8'h01);
      for (int i = 0; i < 4; i++) rd($sformatf("hold.r%0d", i), 16'h4016, 1'b1);
      @(negedge clock); pad1_buttons = 8'h00;
      idle(2);
      rd("hold.clr", 16'h4016, 1'b0);
      wr("hold.w0", 8'h00);

      // Independent ports
      pad1_buttons = 8'hFF; pad2_buttons = 8'h00;
      idle(3);
      wr("ind.w1", 8'h01);
      wr("ind.w0", 8'h00);
      for (int i = 0; i < 8; i++) begin
         rd($sformatf("ind.p1_%0d", i), 16'h4016, 1'b1);
         rd($sformatf("ind.p2_%0d", i), 16'h4017, 1'b0);
      end
      rd("ind.p1_end", 16'h4016, 1'b1);
      rd("ind.p2_end", 16'h4017, 1'b1);

      // Decode: $4017 write and upper data bits ignored, $4018 read has no effect
      bus("dec.w4017", 16'h4017, 1'b0, 8'h01, 1'b0);
      check("dec.strobe4017", {7'b0, strobe}, 8'h00);
      wr("dec.wFE", 8'hFE);
      check("dec.strobeFE", {7'b0, strobe}, 8'h00);
      pad1_buttons = 8'b0000_0010; pad2_buttons = 8'b0000_0001;
      idle(3);
      wr("dec.w1", 8'h01);
      wr("dec.w0", 8'h00);
      rd("dec.r4018a", 16'h4018, 1'b0);
      rd("dec.p1", 16'h4016, 1'b0);
      rd("dec.r4018b", 16'h4018, 1'b0);
      rd("dec.p2", 16'h4017, 1'b1);
      rd("dec.p1b", 16'h4016, 1'b1);
      rd("dec.p2b", 16'h4017, 1'b0);

      // Reset mid-read
      pad1_buttons = 8'hFF;
      idle(3);
      wr("mid.w1", 8'h01);
      wr("mid.w0", 8'h00);
      rd("mid.r0", 16'h4016, 1'b1);
      rd("mid.r1", 16'h4016, 1'b1);
      rd("mid.r2", 16'h4016, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("mid.async_oe", {7'b0, data_oe}, 8'h00);
      check("mid.async_data", data_out, 8'h00);
      @(negedge clock); reset = 1'b0;
      check("mid.strobe", {7'b0, strobe}, 8'h00);
      rd("mid.after0", 16'h4016, 1'b0);
      for (int i = 1; i < 8; i++) rd($sformatf("mid.after%0d", i), 16'h4016, 1'b0);
      rd("mid.fill", 16'h4016, 1'b1);

      check("sb.empty", 8'(exp_q.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
